// File: rtl/eater_pkg.sv
// Shared constants for the microcoded control sequencer: control-bit indices,
// ctrl_word masks and opcode encodings.
package eater_pkg;
  localparam int CW_W = 16;

  localparam int B_HLT = 15;
  localparam int B_MI  = 14;
  localparam int B_RI  = 13;
  localparam int B_RO  = 12;
  localparam int B_IO  = 11;
  localparam int B_II  = 10;
  localparam int B_AI  = 9;
  localparam int B_AO  = 8;
  localparam int B_EO  = 7;
  localparam int B_SU  = 6;
  localparam int B_BI  = 5;
  localparam int B_OI  = 4;
  localparam int B_CE  = 3;
  localparam int B_CO  = 2;
  localparam int B_J   = 1;
  localparam int B_FI  = 0;

  localparam logic [CW_W-1:0] HLT = CW_W'(1) << B_HLT;
  localparam logic [CW_W-1:0] MI  = CW_W'(1) << B_MI;
  localparam logic [CW_W-1:0] RI  = CW_W'(1) << B_RI;
  localparam logic [CW_W-1:0] RO  = CW_W'(1) << B_RO;
  localparam logic [CW_W-1:0] IO  = CW_W'(1) << B_IO;
  localparam logic [CW_W-1:0] II  = CW_W'(1) << B_II;
  localparam logic [CW_W-1:0] AI  = CW_W'(1) << B_AI;
  localparam logic [CW_W-1:0] AO  = CW_W'(1) << B_AO;
  localparam logic [CW_W-1:0] EO  = CW_W'(1) << B_EO;
  localparam logic [CW_W-1:0] SU  = CW_W'(1) << B_SU;
  localparam logic [CW_W-1:0] BI  = CW_W'(1) << B_BI;
  localparam logic [CW_W-1:0] OI  = CW_W'(1) << B_OI;
  localparam logic [CW_W-1:0] CE  = CW_W'(1) << B_CE;
  localparam logic [CW_W-1:0] CO  = CW_W'(1) << B_CO;
  localparam logic [CW_W-1:0] J   = CW_W'(1) << B_J;
  localparam logic [CW_W-1:0] FI  = CW_W'(1) << B_FI;

  typedef enum logic [3:0] {
    OP_NOP = 4'h0, OP_LDA = 4'h1, OP_ADD = 4'h2, OP_SUB = 4'h3,
    OP_STA = 4'h4, OP_LDI = 4'h5, OP_JMP = 4'h6, OP_JC  = 4'h7,
    OP_JZ  = 4'h8, OP_OUT = 4'hE, OP_HLT = 4'hF
  } opcode_e;
endpackage

// File: rtl/microcode_rom.sv
// Purely combinational microcode decoder: {opcode, step, CF, ZF} -> ctrl_word.
// T0/T1 are the common fetch; undefined opcodes and unlisted steps decode to 0.
module microcode_rom
  import eater_pkg::*;
(
  input  logic [3:0]      opcode,
  input  logic [2:0]      step,
  input  logic            cf,
  input  logic            zf,
  output logic [CW_W-1:0] ctrl_word
);
  always_comb begin
    ctrl_word = '0;
    if (step == 3'd0) begin
      ctrl_word = CO | MI;
    end else if (step == 3'd1) begin
      ctrl_word = RO | II | CE;
    end else begin
      case (opcode)
        OP_LDA: case (step)
          3'd2: ctrl_word = IO | MI;
          3'd3: ctrl_word = RO | AI;
          default: ;
        endcase
        OP_ADD: case (step)
          3'd2: ctrl_word = IO | MI;
          3'd3: ctrl_word = RO | BI;
          3'd4: ctrl_word = EO | AI | FI;
          default: ;
        endcase
        OP_SUB: case (step)
          3'd2: ctrl_word = IO | MI;
          3'd3: ctrl_word = RO | BI;
          3'd4: ctrl_word = EO | AI | SU | FI;
          default: ;
        endcase
        OP_STA: case (step)
          3'd2: ctrl_word = IO | MI;
          3'd3: ctrl_word = AO | RI;
          default: ;
        endcase
        OP_LDI: if (step == 3'd2) ctrl_word = IO | AI;
        OP_JMP: if (step == 3'd2) ctrl_word = IO | J;
        // Conditional jumps see only the latched flags, never the live ALU outputs.
        OP_JC:  if (step == 3'd2 && cf) ctrl_word = IO | J;
        OP_JZ:  if (step == 3'd2 && zf) ctrl_word = IO | J;
        OP_OUT: if (step == 3'd2) ctrl_word = AO | OI;
        OP_HLT: if (step == 3'd2) ctrl_word = HLT;
        default: ;
      endcase
    end
  end
endmodule

// File: rtl/control_sequencer.sv
// Microstep counter (falling edge) and {CF,ZF} flag register (rising edge)
// around the microcode decoder. Define EARLY_STEP_RESET_EN to skip idle trailing steps.
module control_sequencer
  import eater_pkg::*;
#(
  parameter int MAX_STEP = 4
) (
  input  logic            system_clock,
  input  logic            clr,
  input  logic [3:0]      opcode,
  input  logic            carry_in,
  input  logic            zero_in,
  output logic [2:0]      step,
  output logic [CW_W-1:0] ctrl_word,
  output logic [1:0]      flags
);
  logic [2:0] step_q, step_d;
  logic [1:0] flags_q, flags_d;

  microcode_rom u_rom (
    .opcode    (opcode),
    .step      (step_q),
    .cf        (flags_q[1]),
    .zf        (flags_q[0]),
    .ctrl_word (ctrl_word)
  );

  always_comb begin
    step_d = (step_q == 3'(MAX_STEP)) ? 3'd0 : step_q + 3'd1;
`ifdef EARLY_STEP_RESET_EN
    if (step_q >= 3'd2 && ctrl_word == '0) step_d = 3'd0;
`endif
    flags_d = {carry_in, zero_in};
  end

  // Stepping on the falling edge leaves a full low phase for ctrl_word to settle.
  always_ff @(negedge system_clock or posedge clr) begin
    if (clr) step_q <= 3'd0;
    else     step_q <= step_d;
  end

  always_ff @(posedge system_clock or posedge clr) begin
    if (clr)                flags_q <= 2'b00;
    else if (ctrl_word[B_FI]) flags_q <= flags_d;
  end

  assign step  = step_q;
  assign flags = flags_q;
endmodule

// File: tb/tb_control_sequencer.sv
// Scoreboard bench for control_sequencer: a per-opcode microstep-list model
// predicts {step, ctrl_word, flags}; a monitor process pops and compares.
module tb_control_sequencer;
  localparam int MS = 4;
  localparam logic [15:0] HLT = 16'h8000, MI = 16'h4000, RI = 16'h2000, RO = 16'h1000,
                          IO  = 16'h0800, II = 16'h0400, AI = 16'h0200, AO = 16'h0100,
                          EO  = 16'h0080, SU = 16'h0040, BI = 16'h0020, OI = 16'h0010,
                          CE  = 16'h0008, CO = 16'h0004, J  = 16'h0002, FI = 16'h0001;

  logic        system_clock = 1'b0;
  logic        clr = 1'b1;
  logic [3:0]  opcode = 4'h0;
  logic        carry_in = 1'b0, zero_in = 1'b0;
  logic [2:0]  step;
  logic [15:0] ctrl_word;
  logic [1:0]  flags;

  control_sequencer #(.MAX_STEP(MS)) dut (
    .system_clock (system_clock),
    .clr          (clr),
    .opcode       (opcode),
    .carry_in     (carry_in),
    .zero_in      (zero_in),
    .step         (step),
    .ctrl_word    (ctrl_word),
    .flags        (flags)
  );

  typedef struct {
    int          tag;
    logic [2:0]  st;
    logic [15:0] cw;
    logic [1:0]  fl;
  } exp_t;

  exp_t q[$];
  int   total = 0;
  int   bad = 0;
  logic chk_req = 1'b0;
  int   m_step = 0;
  logic [1:0] m_fl = 2'b00;

  // Reference: the instruction as a list of microstep words; anything past its end is 0.
  function automatic logic [15:0] ref_word(input logic [3:0] op, input int st, input logic [1:0] fl);
    logic [15:0] seq[$];
    seq.push_back(CO | MI);
    seq.push_back(RO | II | CE);
    case (op)
      4'h1: begin seq.push_back(IO | MI); seq.push_back(RO | AI); end
      4'h2: begin seq.push_back(IO | MI); seq.push_back(RO | BI); seq.push_back(EO | AI | FI); end
      4'h3: begin seq.push_back(IO | MI); seq.push_back(RO | BI); seq.push_back(EO | AI | SU | FI); end
      4'h4: begin seq.push_back(IO | MI); seq.push_back(AO | RI); end
      4'h5: seq.push_back(IO | AI);
      4'h6: seq.push_back(IO | J);
      4'h7: if (fl[1]) seq.push_back(IO | J);
      4'h8: if (fl[0]) seq.push_back(IO | J);
      4'hE: seq.push_back(AO | OI);
      4'hF: seq.push_back(HLT);
      default: ;
    endcase
    if (st < seq.size()) return seq[st];
    return 16'h0000;
  endfunction

  function automatic int next_step(input int st, input logic [15:0] w);
    int n;
    n = (st == MS) ? 0 : st + 1;
`ifdef EARLY_STEP_RESET_EN
    if (st >= 2 && w == 16'h0000) n = 0;
`endif
    return n;
  endfunction

  task automatic push_check(input int tag);
    exp_t e;
    e.tag = tag;
    e.st  = 3'(m_step);
    e.cw  = ref_word(opcode, m_step, m_fl);
    e.fl  = m_fl;
    q.push_back(e);
    chk_req = ~chk_req;
  endtask

  // One clock period, starting and ending in the low phase (10 time units).
  task automatic cycle(input int tag, input bit rnd, input logic c, input logic z, output bit halted);
    logic [15:0] w;
    halted = 1'b0;
    #2;
    if (rnd) begin carry_in = 1'($urandom); zero_in = 1'($urandom); end
    else     begin carry_in = c; zero_in = z; end
    #1 push_check(tag);
    #1 if (rnd) carry_in = ~carry_in;
    #1 push_check(tag);
    w = ref_word(opcode, m_step, m_fl);
    if ((w & HLT) != 16'h0) begin halted = 1'b1; return; end
    system_clock = 1'b1;
    if ((w & FI) != 16'h0) m_fl = {carry_in, zero_in};
    #5 system_clock = 1'b0;
    m_step = next_step(m_step, w);
  endtask

  task automatic run_instr(input logic [3:0] op, input int tag, input bit rnd, input logic c, input logic z);
    int n;
    bit halted;
    n = 0;
    halted = 1'b0;
    opcode = op;
    do begin
      cycle(tag, rnd, c, z, halted);
      n++;
    end while (m_step != 0 && n < 10 && !halted);
    if (halted) begin
      // Clock stage has stopped: state must hold, then clr recovers.
      #20 push_check(tag);
      clr = 1'b1;
      m_step = 0;
      m_fl = 2'b00;
      #1 push_check(tag);
      #3 clr = 1'b0;
    end
  endtask

  task automatic cmp(input int tag, input string nm, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s tag=%0d act=%h exp=%h (t=%0t)", nm, tag, act, exp, $time);
    end
  endtask

  initial begin
    exp_t e;
    forever begin
      @(chk_req);
      while (q.size() > 0) begin
        e = q.pop_front();
        cmp(e.tag, "step", 16'(step), 16'(e.st));
        cmp(e.tag, "ctrl_word", ctrl_word, e.cw);
        cmp(e.tag, "flags", 16'(flags), 16'(e.fl));
      end
    end
  end

  initial begin
    bit h;
    #3 push_check(0);
    #2 clr = 1'b0;

    run_instr(4'h2, 1, 1'b0, 1'b1, 1'b0);
    run_instr(4'h7, 2, 1'b0, 1'b0, 1'b0);
    run_instr(4'h3, 3, 1'b0, 1'b0, 1'b1);
    run_instr(4'h7, 4, 1'b1, 1'b0, 1'b0);
    run_instr(4'h8, 5, 1'b1, 1'b0, 1'b0);
    run_instr(4'h5, 6, 1'b1, 1'b0, 1'b0);
    run_instr(4'hE, 7, 1'b1, 1'b0, 1'b0);
    run_instr(4'hB, 8, 1'b1, 1'b0, 1'b0);
    run_instr(4'h4, 9, 1'b1, 1'b0, 1'b0);
    run_instr(4'h1, 10, 1'b1, 1'b0, 1'b0);
    run_instr(4'h6, 11, 1'b1, 1'b0, 1'b0);
    run_instr(4'h0, 12, 1'b1, 1'b0, 1'b0);

    // Abort an ADD at T3 during the high phase, no clock edge involved.
    opcode = 4'h2;
    repeat (3) cycle(13, 1'b1, 1'b0, 1'b0, h);
    #2 system_clock = 1'b1;
    #2 clr = 1'b1;
    m_step = 0;
    m_fl = 2'b00;
    #1 push_check(13);
    #1 system_clock = 1'b0;
    #2 clr = 1'b0;
    run_instr(4'h2, 14, 1'b0, 1'b1, 1'b1);

    // clr coinciding with a falling edge.
    opcode = 4'h5;
    cycle(15, 1'b1, 1'b0, 1'b0, h);
    cycle(15, 1'b1, 1'b0, 1'b0, h);
    #5 system_clock = 1'b1;
    #5 clr = 1'b1;
    system_clock = 1'b0;
    m_step = 0;
    m_fl = 2'b00;
    #1 push_check(15);
    #2 clr = 1'b0;

    run_instr(4'hF, 16, 1'b1, 1'b0, 1'b0);

    for (int i = 0; i < 80; i++)
      run_instr(4'($urandom_range(0, 15)), 100 + i, 1'b1, 1'b0, 1'b0);

    #5;
    total++;
    if (q.size() != 0) begin
      bad++;
      $display("FAIL scoreboard_drain left=%0d exp=0", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
